sincos_arbiter: RTL and testbench

SINCOS_ARBITER -- requirements
Module: sincos_arbiter

---
 rtl/sincos_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sincos_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_arbiter.sv
// Two-requester front end for one shared pipelined sine_calculator: round-robin issue,
// credit-gated per-requester result FIFOs, and a tag pipeline that steers results home.
module sincos_arbiter #(
  parameter int EXP_LEN      = 8,
  parameter int MANTISSA_LEN = 23,
  parameter int CALC_LATENCY = 3,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req0_valid,
  output logic                            req0_ready,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   req0_theta,
  input  logic                            req0_sine_cosine,
  input  logic                            req1_valid,
  output logic                            req1_ready,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   req1_theta,
  input  logic                            req1_sine_cosine,
  output logic                            rsp0_valid,
  input  logic                            rsp0_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   rsp0_value,
  output logic                            rsp1_valid,
  input  logic                            rsp1_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   rsp1_value,
  output logic                            calc_enable,
  output logic [EXP_LEN+MANTISSA_LEN:0]   calc_theta,
  output logic                            calc_sine_cosine,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   calc_value
);

  localparam int W  = EXP_LEN + MANTISSA_LEN + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]   req_valid;
  logic [1:0]   rsp_ready;
  logic [1:0]   eligible;
  logic [1:0]   cand;
  logic [1:0]   grant;
  logic [1:0]   issue;
  logic [1:0]   fifo_valid;
  logic [W-1:0] fifo_head [2];

  logic                    last_grant_q, last_grant_d;
  logic [CALC_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [CALC_LATENCY-1:0] tag_id_q, tag_id_d;
  logic                    wr_valid;
  logic                    wr_id;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Only requesters with a free result slot (queued or in flight) may compete.
  always_comb begin
    cand  = req_valid & eligible;
    grant = cand;
    if (cand == 2'b11) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end
  end

  assign issue      = grant & {2{rst_n}};
  assign req0_ready = issue[0];
  assign req1_ready = issue[1];

  always_comb begin
    calc_enable      = |issue;
    calc_theta       = '0;
    calc_sine_cosine = 1'b0;
    if (issue[0]) begin
      calc_theta       = req0_theta;
      calc_sine_cosine = req0_sine_cosine;
    end else if (issue[1]) begin
      calc_theta       = req1_theta;
      calc_sine_cosine = req1_sine_cosine;
    end
  end

  always_comb begin
    last_grant_d   = (|issue) ? issue[1] : last_grant_q;
    tag_valid_d    = tag_valid_q;
    tag_id_d       = tag_id_q;
    tag_valid_d[0] = |issue;
    tag_id_d[0]    = issue[1];
    for (int i = 1; i < CALC_LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_id_d[i]    = tag_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      tag_valid_q  <= '0;
      tag_id_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      tag_valid_q  <= tag_valid_d;
      tag_id_q     <= tag_id_d;
    end
  end

  // The last tag stage lines up with calc_value for the request it describes.
  assign wr_valid = tag_valid_q[CALC_LATENCY-1];
  assign wr_id    = tag_id_q[CALC_LATENCY-1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      push     = wr_valid && (wr_id == 1'(gi)) && !full;
      pop      = !empty && rsp_ready[gi];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (issue[gi] && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!issue[gi] && pop) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= calc_value;
      end
    end

    assign eligible[gi]   = (cnt_q < CW'(FIFO_DEPTH));
    assign fifo_valid[gi] = !empty;
    assign fifo_head[gi]  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // FIFO storage has no reset, so the head is masked while reset is held.
  assign rsp0_valid = rst_n & fifo_valid[0];
  assign rsp1_valid = rst_n & fifo_valid[1];
  assign rsp0_value = rst_n ? fifo_head[0] : '0;
  assign rsp1_value = rst_n ? fifo_head[1] : '0;

endmodule

// File: tb/tb_sincos_arbiter.sv
// Bench for sincos_arbiter: pipelined calculator model, queue-based reference of
// credits/round-robin/latency, directed scenarios and a randomized phase.
module tb_sincos_arbiter;

  localparam int DEPTH = 4;
  localparam int LAT   = 3;

  typedef struct {
    logic [31:0] val;
    int unsigned cyc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_sine_cosine;
  logic        req1_valid, req1_ready, req1_sine_cosine;
  logic [31:0] req0_theta, req1_theta;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_value, rsp1_value;
  logic        calc_enable, calc_sine_cosine;
  logic [31:0] calc_theta, calc_value;

  int          n_chk = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  ent_t        q0[$];
  ent_t        q1[$];
  logic        last_model = 1'b1;
  logic [1:0]  prev_stall = 2'b00;
  logic [31:0] prev_val [2];
  logic [31:0] pipe [LAT];
  logic        c0, c1;
  logic [1:0]  g;

  sincos_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_theta(req0_theta), .req0_sine_cosine(req0_sine_cosine),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_theta(req1_theta), .req1_sine_cosine(req1_sine_cosine),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_value(rsp0_value),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_value(rsp1_value),
    .calc_enable(calc_enable), .calc_theta(calc_theta),
    .calc_sine_cosine(calc_sine_cosine), .calc_value(calc_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] calc_model(input logic [31:0] th, input logic sc);
    return sc ? ({th[15:0], th[31:16]} ^ 32'hA5A5_0F0F) : (th * 32'd3 + 32'd7);
  endfunction

  // External calculator: fixed latency, no reset.
  always @(posedge clk) begin
    pipe[0] <= calc_enable ? calc_model(calc_theta, calc_sine_cosine) : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    cyc <= cyc + 1;
  end
  assign calc_value = pipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic mon_rsp(input int k, ref ent_t q[$], input logic v, input logic r,
                         input logic [31:0] val);
    ent_t e;
    logic exp_v;
    exp_v = (q.size() > 0) && (cyc >= q[0].cyc + LAT + 1);
    check($sformatf("rsp%0d_valid", k), v, exp_v);
    if (prev_stall[k] && v) check($sformatf("rsp%0d_hold", k), val, prev_val[k]);
    if (v && r && q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("rsp%0d_value", k), val, e.val);
    end
    prev_stall[k] = v && !r;
    prev_val[k]   = val;
  endtask

  // Reference model: credits are queue occupancies, responses due LAT+1 cycles after issue.
  always @(negedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      last_model = 1'b1;
      prev_stall = 2'b00;
    end else begin
      c0 = req0_valid && (q0.size() < DEPTH);
      c1 = req1_valid && (q1.size() < DEPTH);
      g  = (c0 && c1) ? (last_model ? 2'b01 : 2'b10) : {c1, c0};
      check("grant", {req1_ready, req0_ready}, g);
      check("calc_enable", calc_enable, |g);
      if (g[0]) check("calc_op0", {calc_sine_cosine, calc_theta}, {req0_sine_cosine, req0_theta});
      else if (g[1]) check("calc_op1", {calc_sine_cosine, calc_theta}, {req1_sine_cosine, req1_theta});
      else check("calc_idle", {calc_sine_cosine, calc_theta}, 0);
      mon_rsp(0, q0, rsp0_valid, rsp0_ready, rsp0_value);
      mon_rsp(1, q1, rsp1_valid, rsp1_ready, rsp1_value);
      if (g[0]) q0.push_back('{calc_model(req0_theta, req0_sine_cosine), cyc});
      if (g[1]) q1.push_back('{calc_model(req1_theta, req1_sine_cosine), cyc});
      if (g != 2'b00) last_model = g[1];
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(input int k);
    if (k == 0) begin
      req0_theta = $urandom; req0_sine_cosine = 1'($urandom);
    end else begin
      req1_theta = $urandom; req1_sine_cosine = 1'($urandom);
    end
  endtask

  task automatic idle(input int n);
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (n) next_cycle();
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle(1);
    rst_n = 1;
  endtask

  initial begin
    logic [11:0] p0, p1;
    logic        a0, a1, any_v;
    logic [31:0] head;
    int          n;

    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    new_op(0); new_op(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {req1_ready, req0_ready}, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_rsp_value", {rsp1_value, rsp0_value}, 0);
    check("rst_calc", {calc_enable, calc_sine_cosine, calc_theta}, 0);
    next_cycle();
    rst_n = 1;

    // Single request latency
    req1_valid = 0; req0_valid = 1; req0_theta = 32'h3F80_0000; req0_sine_cosine = 1;
    @(negedge clk);
    check("r028_enable", {req0_ready, calc_enable}, 2'b11);
    check("r028_theta", {calc_sine_cosine, calc_theta}, {1'b1, 32'h3F80_0000});
    next_cycle();
    req0_valid = 0;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      check($sformatf("r028_valid_c%0d", d), rsp0_valid, d == 4);
      if (d == 4) check("r028_value", rsp0_value, calc_model(32'h3F80_0000, 1'b1));
      next_cycle();
    end
    idle(4);

    // Streaming throughput
    req0_valid = 1; new_op(0); p0 = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      p0[c] = req0_ready; a0 = req0_ready;
      next_cycle();
      if (a0) new_op(0);
    end
    check("r031_issue_cycles", p0[8:0], 9'b1_1110_1111);
    idle(10);

    // Backpressure fills the credits
    req0_valid = 1; rsp0_ready = 0; new_op(0); p0 = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      p0[c] = req0_ready; a0 = req0_ready;
      next_cycle();
      if (a0) new_op(0);
    end
    check("r030_issue_cycles", p0[9:0], 10'b00_0000_1111);
    rsp0_ready = 1;
    @(negedge clk);
    check("r030_pop", {rsp0_valid, req0_ready}, 2'b10);
    next_cycle();
    rsp0_ready = 0; n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a0 = req0_ready;
      if (a0) n++;
      next_cycle();
      if (a0) new_op(0);
    end
    check("r030_one_more", n, 1);
    idle(12);

    // Contention alternates starting with req0
    do_reset();
    req0_valid = 1; req1_valid = 1; new_op(0); new_op(1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      p0[c] = req0_ready; p1[c] = req1_ready; a0 = req0_ready; a1 = req1_ready;
      next_cycle();
      if (a0) new_op(0);
      if (a1) new_op(1);
    end
    check("r029_grant0", p0, 12'h555);
    check("r029_grant1", p1, 12'hAAA);
    idle(12);

    // Reset with results in flight
    req0_valid = 1; new_op(0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("r032_issue%0d", c), req0_ready, 1'b1);
      next_cycle();
      new_op(0);
    end
    rst_n = 0; req0_valid = 0;
    next_cycle();
    rst_n = 1; any_v = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      any_v = any_v | rsp0_valid | rsp1_valid;
      next_cycle();
    end
    check("r032_no_rsp", any_v, 1'b0);
    req0_valid = 1; new_op(0);
    @(negedge clk);
    check("r032_reissue", req0_ready, 1'b1);
    next_cycle();
    req0_valid = 0;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      check($sformatf("r032_valid_c%0d", d), rsp0_valid, d == 4);
      next_cycle();
    end
    idle(6);

    // Head stall on req1
    n = 0; head = '0; new_op(1);
    for (int c = 0; c < 12; c++) begin
      req1_valid = (n < 3); rsp1_ready = (c >= 6);
      @(negedge clk);
      a1 = req1_ready;
      if (c == 4) begin
        check("r033_head_valid", rsp1_valid, 1'b1);
        head = rsp1_value;
      end
      if (c == 5 || c == 6) check($sformatf("r033_head_c%0d", c), {rsp1_valid, rsp1_value}, {1'b1, head});
      next_cycle();
      if (a1) begin n++; new_op(1); end
    end
    idle(4);
    check("r033_drained", q1.size(), 0);

    // Randomized traffic: heavy backpressure first, then light
    for (int c = 0; c < 400; c++) begin
      if (!req0_valid) begin req0_valid = ($urandom_range(0, 3) != 0); new_op(0); end
      if (!req1_valid) begin req1_valid = ($urandom_range(0, 3) != 0); new_op(1); end
      rsp0_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rsp1_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      a0 = req0_ready; a1 = req1_ready;
      next_cycle();
      if (a0) req0_valid = 0;
      if (a1) req1_valid = 0;
    end
    idle(15);
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    @(negedge clk);
    check("final_rsp_idle", {rsp1_valid, rsp0_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
